// File: rtl/instr_seq.sv
// Instruction sequencer: a small instruction FIFO filled by the host and
// drained one word at a time into the processor. Each word is presented
// for a single ISSUE cycle. The sequencer then waits for the processor's
// Done strobe. If Done never arrives, a watchdog moves the sequencer into
// a sticky ERROR state.
module instr_seq #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        WrEn,
    input  logic [15:0] WrData,
    input  logic        Start,
    input  logic        Clear,
    input  logic        Done,
    output logic [15:0] DIN,
    output logic        Run,
    output logic        Full,
    output logic        Empty,
    output logic        Busy,
    output logic        Err,
    output logic        Ovf,
    output logic [7:0]  ExecCount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [1:0]    state_r;
    logic [TW-1:0] wait_cnt_r;
    logic [7:0]    exec_count_r;
    logic          err_r;
    logic          ovf_r;

    logic [1:0]    state_n_s;
    logic [TW-1:0] wait_cnt_n_s;
    logic [7:0]    exec_count_n_s;
    logic          err_n_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_set_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == {CW{1'b0}});
    // The head leaves the FIFO at the end of the ISSUE cycle. Because the
    // pop frees a slot, a push in the same cycle is legal even when full.
    assign pop_s     = (state_r == S_ISSUE) && !empty_s;
    assign push_s    = WrEn && (!full_s || pop_s);
    assign ovf_set_s = WrEn && full_s && !pop_s;

    // Next-state logic for the sequencer FSM, watchdog and completion count
    always_comb begin
        state_n_s      = state_r;
        wait_cnt_n_s   = wait_cnt_r;
        exec_count_n_s = exec_count_r;
        err_n_s        = err_r;
        case (state_r)
            S_IDLE: begin
                if (Start && !empty_s) begin
                    state_n_s      = S_ISSUE;
                    exec_count_n_s = 8'd0;
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_n_s    = S_WAIT;
                wait_cnt_n_s = {TW{1'b0}};
            end
            S_WAIT: begin
                if (Done) begin
                    exec_count_n_s = exec_count_r + 8'd1;
                    wait_cnt_n_s   = {TW{1'b0}};
                    if (!empty_s) begin
                        state_n_s = S_ISSUE;
                    end else begin
                        state_n_s = S_IDLE;
                    end
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    state_n_s = S_ERROR;
                    err_n_s   = 1'b1;
                end else begin
                    wait_cnt_n_s = wait_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            S_ERROR: begin
                state_n_s = S_ERROR;
            end
            default: begin
                state_n_s = S_IDLE;
            end
        endcase
    end

    // Control state: reset clears everything, Clear flushes and recovers but keeps ExecCount
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_r      <= S_IDLE;
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            wait_cnt_r   <= {TW{1'b0}};
            exec_count_r <= 8'd0;
            err_r        <= 1'b0;
            ovf_r        <= 1'b0;
        end else if (Clear) begin
            state_r    <= S_IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            wait_cnt_r <= {TW{1'b0}};
            err_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            wait_cnt_r   <= wait_cnt_n_s;
            exec_count_r <= exec_count_n_s;
            err_r        <= err_n_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            end else if (pop_s && !push_s) begin
                count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage; a push coincident with reset or Clear is discarded
    always_ff @(posedge Clock) begin
        if (Resetn && !Clear && push_s) begin
            mem_r[wr_ptr_r] <= WrData;
        end
    end

    // Moore output decode: the head word is visible only during ISSUE
    always_comb begin
        if (state_r == S_ISSUE) begin
            DIN = mem_r[rd_ptr_r];
            Run = 1'b1;
        end else begin
            DIN = 16'h0000;
            Run = 1'b0;
        end
    end

    assign Busy      = (state_r == S_ISSUE) || (state_r == S_WAIT);
    assign Full      = full_s;
    assign Empty     = empty_s;
    assign Err       = err_r;
    assign Ovf       = ovf_r;
    assign ExecCount = exec_count_r;

endmodule

// File: tb/tb_instr_seq.sv
// Directed testbench for instr_seq (DEPTH=8, TIMEOUT=8).
// Inputs change 1 ns after a rising edge. Outputs are checked at that
// same point, so they reflect the state the preceding edge produced.
module tb_instr_seq;

    logic        Clock;
    logic        Resetn;
    logic        WrEn;
    logic [15:0] WrData;
    logic        Start;
    logic        Clear;
    logic        Done;
    logic [15:0] DIN;
    logic        Run;
    logic        Full;
    logic        Empty;
    logic        Busy;
    logic        Err;
    logic        Ovf;
    logic [7:0]  ExecCount;

    int compared;
    int mismatched;

    instr_seq #(.DEPTH(8), .TIMEOUT(8)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .WrEn      (WrEn),
        .WrData    (WrData),
        .Start     (Start),
        .Clear     (Clear),
        .Done      (Done),
        .DIN       (DIN),
        .Run       (Run),
        .Full      (Full),
        .Empty     (Empty),
        .Busy      (Busy),
        .Err       (Err),
        .Ovf       (Ovf),
        .ExecCount (ExecCount)
    );

    // 100 MHz clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " Empty"},     {31'd0, Empty},     32'd1);
        check({tag, " Full"},      {31'd0, Full},      32'd0);
        check({tag, " Err"},       {31'd0, Err},       32'd0);
        check({tag, " Ovf"},       {31'd0, Ovf},       32'd0);
        check({tag, " ExecCount"}, {24'd0, ExecCount}, 32'd0);
        check({tag, " Run"},       {31'd0, Run},       32'd0);
        check({tag, " DIN"},       {16'd0, DIN},       32'd0);
        check({tag, " Busy"},      {31'd0, Busy},      32'd0);
    endtask

    task automatic push(input logic [15:0] w);
        WrEn   = 1'b1;
        WrData = w;
        tick();
        WrEn   = 1'b0;
    endtask

    // Directed stimulus sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        Resetn = 1'b0; WrEn = 1'b0; WrData = 16'h0000;
        Start  = 1'b0; Clear = 1'b0; Done = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        Resetn = 1'b1;

        // Three-instruction program; mv completes in its first WAIT cycle (2-cycle Run spacing)
        push(16'h1005);
        push(16'h1203);
        push(16'h4200);
        check("prog Empty", {31'd0, Empty}, 32'd0);
        Start = 1'b1;
        tick();                                  // ISSUE #0
        Start = 1'b0;
        check("prog run0",  {31'd0, Run},  32'd1);
        check("prog din0",  {16'd0, DIN},  32'h1005);
        check("prog busy0", {31'd0, Busy}, 32'd1);
        check("prog cnt0",  {24'd0, ExecCount}, 32'd0);
        tick();                                  // WAIT
        check("prog run_w0", {31'd0, Run}, 32'd0);
        check("prog din_w0", {16'd0, DIN}, 32'h0000);
        Done = 1'b1;
        tick();                                  // ISSUE #1
        Done = 1'b0;
        check("prog run1", {31'd0, Run}, 32'd1);
        check("prog din1", {16'd0, DIN}, 32'h1203);
        check("prog cnt1", {24'd0, ExecCount}, 32'd1);
        tick();                                  // WAIT
        Done = 1'b1;
        tick();                                  // ISSUE #2 (add)
        Done = 1'b0;
        check("prog run2", {31'd0, Run}, 32'd1);
        check("prog din2", {16'd0, DIN}, 32'h4200);
        check("prog cnt2", {24'd0, ExecCount}, 32'd2);
        tick();                                  // WAIT1
        check("prog add_w1 run", {31'd0, Run}, 32'd0);
        tick();                                  // WAIT2
        tick();                                  // WAIT3
        check("prog add_w3 busy", {31'd0, Busy}, 32'd1);
        Done = 1'b1;
        tick();                                  // IDLE
        Done = 1'b0;
        check("prog end cnt",   {24'd0, ExecCount}, 32'd3);
        check("prog end busy",  {31'd0, Busy},      32'd0);
        check("prog end empty", {31'd0, Empty},     32'd1);
        check("prog end run",   {31'd0, Run},       32'd0);

        // add followed by mv: add takes 3 WAIT cycles, giving a 4-cycle Run spacing
        push(16'h4200);
        push(16'h1005);
        Start = 1'b1;
        tick();                                  // ISSUE add
        Start = 1'b0;
        check("space run_add", {31'd0, Run}, 32'd1);
        tick();
        check("space t1 run", {31'd0, Run}, 32'd0);
        tick();
        check("space t2 run", {31'd0, Run}, 32'd0);
        tick();
        check("space t3 run", {31'd0, Run}, 32'd0);
        Done = 1'b1;
        tick();                                  // ISSUE mv, 4 cycles after add
        Done = 1'b0;
        check("space t4 run", {31'd0, Run}, 32'd1);
        check("space t4 din", {16'd0, DIN}, 32'h1005);
        tick();
        Done = 1'b1;
        tick();                                  // IDLE
        Done = 1'b0;
        check("space end cnt", {24'd0, ExecCount}, 32'd2);

        // Start with an empty FIFO is ignored and does not clear ExecCount
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("empty start run",  {31'd0, Run},  32'd0);
        check("empty start busy", {31'd0, Busy}, 32'd0);
        check("empty start cnt",  {24'd0, ExecCount}, 32'd2);

        // Nine pushes into an 8-entry FIFO: ninth dropped, Ovf set, eight executed
        for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i));
        check("ovf full8",  {31'd0, Full}, 32'd1);
        check("ovf before", {31'd0, Ovf},  32'd0);
        push(16'h2008);
        check("ovf set",   {31'd0, Ovf},  32'd1);
        check("ovf full9", {31'd0, Full}, 32'd1);
        Start = 1'b1;
        tick();                                  // ISSUE #0
        Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf run%0d", i), {31'd0, Run}, 32'd1);
            check($sformatf("ovf din%0d", i), {16'd0, DIN}, 32'h2000 + i);
            tick();                              // WAIT
            Done = 1'b1;
            tick();                              // next ISSUE or IDLE
            Done = 1'b0;
        end
        check("ovf end run",   {31'd0, Run},       32'd0);
        check("ovf end busy",  {31'd0, Busy},      32'd0);
        check("ovf end cnt",   {24'd0, ExecCount}, 32'd8);
        check("ovf end empty", {31'd0, Empty},     32'd1);
        check("ovf sticky",    {31'd0, Ovf},       32'd1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clear ovf",  {31'd0, Ovf},       32'd0);
        check("clear held", {24'd0, ExecCount}, 32'd8);

        // Push while full during ISSUE is accepted because of the simultaneous pop
        for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i));
        check("pp full", {31'd0, Full}, 32'd1);
        Start = 1'b1;
        tick();                                  // ISSUE, FIFO still full
        Start = 1'b0;
        check("pp issue run",  {31'd0, Run},  32'd1);
        check("pp issue full", {31'd0, Full}, 32'd1);
        WrEn = 1'b1; WrData = 16'h3008;
        tick();                                  // WAIT
        WrEn = 1'b0;
        check("pp ovf",  {31'd0, Ovf},  32'd0);
        check("pp full", {31'd0, Full}, 32'd1);
        for (int i = 1; i < 9; i++) begin
            Done = 1'b1;
            tick();                              // ISSUE i
            Done = 1'b0;
            check($sformatf("pp din%0d", i), {16'd0, DIN}, 32'h3000 + i);
            tick();                              // WAIT
        end
        Done = 1'b1;
        tick();                                  // IDLE
        Done = 1'b0;
        check("pp end cnt",   {24'd0, ExecCount}, 32'd9);
        check("pp end empty", {31'd0, Empty},     32'd1);

        // Timeout: eight WAIT cycles without Done lead to ERROR
        push(16'h5000);
        push(16'h5001);
        push(16'h5002);
        Start = 1'b1;
        tick();                                  // ISSUE
        Start = 1'b0;
        tick();                                  // WAIT1
        for (int i = 2; i <= 8; i++) tick();     // WAIT8
        check("to w8 busy", {31'd0, Busy}, 32'd1);
        check("to w8 err",  {31'd0, Err},  32'd0);
        tick();                                  // ERROR
        check("to err",  {31'd0, Err},  32'd1);
        check("to busy", {31'd0, Busy}, 32'd0);
        check("to run",  {31'd0, Run},  32'd0);
        Done = 1'b1; Start = 1'b1;
        tick();                                  // Done and Start ignored in ERROR
        Done = 1'b0; Start = 1'b0;
        check("to hold err",  {31'd0, Err},       32'd1);
        check("to hold run",  {31'd0, Run},       32'd0);
        check("to hold cnt",  {24'd0, ExecCount}, 32'd0);
        check("to retained",  {31'd0, Empty},     32'd0);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("to clr err",   {31'd0, Err},   32'd0);
        check("to clr empty", {31'd0, Empty}, 32'd1);
        check("to clr busy",  {31'd0, Busy},  32'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("to clr idle", {31'd0, Run}, 32'd0);

        // ExecCount wraps 255 -> 0 over a long back-to-back run
        push(16'h7000);
        WrEn = 1'b1; WrData = 16'h7001; Start = 1'b1;
        tick();                                  // ISSUE
        Start = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            tick();                              // WAIT
            Done = 1'b1;
            tick();                              // ISSUE, k completions
            Done = 1'b0;
            if (k == 255) check("wrap 255", {24'd0, ExecCount}, 32'd255);
        end
        check("wrap 0",   {24'd0, ExecCount}, 32'd0);
        check("wrap run", {31'd0, Run},       32'd1);
        WrEn = 1'b0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;

        // Reset during WAIT with four entries queued
        for (int i = 0; i < 5; i++) push(16'h6000 + 16'(i));
        Start = 1'b1;
        tick();                                  // ISSUE
        Start = 1'b0;
        tick();                                  // WAIT, 4 queued
        check("rst pre busy", {31'd0, Busy}, 32'd1);
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        check_reset_values("midrst");
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("midrst start run",  {31'd0, Run},  32'd0);
        check("midrst start busy", {31'd0, Busy}, 32'd0);
        tick();
        check("midrst later run", {31'd0, Run}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
